// File: rtl/voq_ingress_pkg.sv
// voq_ingress_pkg -- shared defaults and types for the VOQ ingress slice.
//   Default sizing for voq_ingress (port count, word width, queue depth,
//   longest admissible packet) and the ingress FSM state type.
//   Optional macro VOQ_DROP_EN adds the DROP state to the FSM.
package voq_ingress_pkg;

  localparam int unsigned PORT_NUB_TOTAL    = 4;
  localparam int unsigned DATA_WIDTH_DEF    = 32;
  localparam int unsigned VOQ_DEPTH_DEF     = 16;
  localparam int unsigned MAX_PKT_WORDS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef VOQ_DROP_EN
    ST_DROP = 2'd2,
`endif
    ST_PKT  = 2'd1
  } voq_state_e;

endpackage

// File: rtl/voq_fifo_ctrl.sv
// voq_fifo_ctrl -- pointer/count bookkeeping for one circular VOQ.
//   clk, rst_n : clock, async active-low reset
//   wr_en      : write request (refused internally when full)
//   rd_en      : pop request (ignored when empty)
//   wr_ptr     : slot the next written word goes to
//   rd_ptr     : slot of the oldest stored word
//   count      : words held, 0..DEPTH
//   pop        : a pop actually happens this cycle
module voq_fifo_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             pop
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;

  always_comb begin
    push     = wr_en && (count_q != CNT_W'(DEPTH));
    pop      = rd_en && (count_q != '0);
    // DEPTH is a power of two, so plain pointer overflow is the wrap.
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/voq_ingress.sv
// voq_ingress -- ingress port buffer with one virtual output queue per
// destination port, sharing a single RAM partitioned into circular queues.
//   clk, rst_n         : clock, async active-low reset
//   in_valid/in_ready  : ingress word handshake
//   in_sop/in_eop      : first/last word of a packet
//   in_dest            : destination port, sampled on the SOP word
//   in_data            : word payload
//   rd_en[d]           : pop VOQ d
//   rd_data[d*W +: W]  : last word popped from VOQ d (registered)
//   empty_out[d]       : VOQ d holds no words
//   drop_cnt           : packets dropped on admission (saturating)
// Macro VOQ_DROP_EN: drop packets whose VOQ is too full at SOP instead of
// relying purely on backpressure; without it drop_cnt is tied to zero.
module voq_ingress
  import voq_ingress_pkg::*;
#(
  parameter int unsigned PORT_NUB      = PORT_NUB_TOTAL,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned VOQ_DEPTH     = VOQ_DEPTH_DEF,
  parameter int unsigned MAX_PKT_WORDS = MAX_PKT_WORDS_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_sop,
  input  logic                           in_eop,
  input  logic [$clog2(PORT_NUB)-1:0]    in_dest,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [PORT_NUB-1:0]            rd_en,
  output logic [PORT_NUB*DATA_WIDTH-1:0] rd_data,
  output logic [PORT_NUB-1:0]            empty_out,
  output logic [15:0]                    drop_cnt
);

  localparam int unsigned DEST_W = $clog2(PORT_NUB);
  localparam int unsigned PTR_W  = $clog2(VOQ_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [PORT_NUB*VOQ_DEPTH];

  voq_state_e          state_q, state_d;
  logic [DEST_W-1:0]   cur_dest_q, cur_dest_d;
  logic [PORT_NUB*DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [PTR_W-1:0]      wr_ptr [PORT_NUB];
  logic [PTR_W-1:0]      rd_ptr [PORT_NUB];
  logic [CNT_W-1:0]      count  [PORT_NUB];
  logic [DATA_WIDTH-1:0] rd_word[PORT_NUB];
  logic [PORT_NUB-1:0]   full, empty, pop, wr_en;
  logic [DEST_W-1:0]     wr_dest;
  logic                  write;

  // SOP words in IDLE steer by in_dest directly; the rest of the packet
  // follows the destination latched at SOP.
  assign wr_dest = (state_q == ST_IDLE) ? in_dest : cur_dest_q;

  for (genvar g = 0; g < PORT_NUB; g++) begin : g_voq
    voq_fifo_ctrl #(
      .DEPTH (VOQ_DEPTH)
    ) u_ctrl (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en[g]),
      .rd_en  (rd_en[g]),
      .wr_ptr (wr_ptr[g]),
      .rd_ptr (rd_ptr[g]),
      .count  (count[g]),
      .pop    (pop[g])
    );
    assign wr_en[g]   = write && (wr_dest == DEST_W'(g));
    assign full[g]    = (count[g] == CNT_W'(VOQ_DEPTH));
    assign empty[g]   = (count[g] == '0);
    assign rd_word[g] = mem[{DEST_W'(g), rd_ptr[g]}];
  end

`ifdef VOQ_DROP_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop_hit;
  assign drop_hit = (count[in_dest] > CNT_W'(VOQ_DEPTH - MAX_PKT_WORDS));
`endif

  always_comb begin
    state_d    = state_q;
    cur_dest_d = cur_dest_q;
    in_ready   = 1'b1;
    write      = 1'b0;
`ifdef VOQ_DROP_EN
    drop_cnt_d = drop_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef VOQ_DROP_EN
        if (in_sop && drop_hit) begin
          if (in_valid) begin
            cur_dest_d = in_dest;
            if (!in_eop) state_d = ST_DROP;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end else
`endif
        if (in_sop) begin
          in_ready = ~full[in_dest];
          if (in_valid && in_ready) begin
            write      = 1'b1;
            cur_dest_d = in_dest;
            if (!in_eop) state_d = ST_PKT;
          end
        end
      end
      ST_PKT: begin
        in_ready = ~full[cur_dest_q];
        if (in_valid && in_ready) begin
          write = 1'b1;
          if (in_eop) state_d = ST_IDLE;
        end
      end
`ifdef VOQ_DROP_EN
      ST_DROP: begin
        if (in_valid && in_eop) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data_d = rd_data_q;
    for (int unsigned d = 0; d < PORT_NUB; d++) begin
      if (pop[d]) rd_data_d[d*DATA_WIDTH +: DATA_WIDTH] = rd_word[d];
    end
  end

  always_ff @(posedge clk) begin
    if (write) mem[{wr_dest, wr_ptr[wr_dest]}] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_dest_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_dest_q <= cur_dest_d;
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef VOQ_DROP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end
  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  assign rd_data   = rd_data_q;
  assign empty_out = empty;

endmodule

// File: tb/tb_voq_ingress.sv
// tb_voq_ingress -- self-checking bench for voq_ingress (default sizing:
// 4 ports, 32-bit words, 16-word queues, 8-word max packet). The reference
// model keeps one word queue per destination and applies the admission,
// backpressure and pop rules directly. Honours VOQ_DROP_EN when defined.
module tb_voq_ingress;

  localparam int NP = 4;
  localparam int DEPTH = 16;
  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sop, in_eop;
  logic [1:0]  in_dest;
  logic [31:0] in_data;
  logic [3:0]  rd_en;
  logic [127:0] rd_data;
  logic [3:0]  empty_out;
  logic [15:0] drop_cnt;

  voq_ingress #(
    .PORT_NUB      (NP),
    .DATA_WIDTH    (32),
    .VOQ_DEPTH     (DEPTH),
    .MAX_PKT_WORDS (MAXW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty_out (empty_out),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = between packets, 1 = storing, 2 = discarding.
  logic [31:0] mq [NP][$];
  int          mode;
  int          mcur;
  int          mdrop;
  logic [31:0] mrd [NP];
  bit          last_acc;
  bit          last_rdy;

  function automatic bit too_full(input int d);
`ifdef VOQ_DROP_EN
    return mq[d].size() > DEPTH - MAXW;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_ready();
    if (mode == 2) return 1'b1;
    if (mode == 1) return mq[mcur].size() < DEPTH;
    if (!in_sop) return 1'b1;
    if (too_full(int'(in_dest))) return 1'b1;
    return mq[in_dest].size() < DEPTH;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < NP; d++) begin
      mq[d].delete();
      mrd[d] = '0;
    end
    mode = 0; mcur = 0; mdrop = 0;
  endtask

  task automatic step();
    bit r;
    bit popme [NP];
    logic [3:0] e;
    #1;
    r = exp_ready();
    last_rdy = in_ready;
    check("in_ready", in_ready, r);
    @(posedge clk);
    last_acc = in_valid && r;
    for (int d = 0; d < NP; d++) popme[d] = rd_en[d] && (mq[d].size() > 0);
    if (last_acc) begin
      case (mode)
        0: if (in_sop) begin
             if (too_full(int'(in_dest))) begin
               if (!in_eop) mode = 2;
               if (mdrop < 65535) mdrop++;
             end else begin
               mq[in_dest].push_back(in_data);
               if (!in_eop) begin mode = 1; mcur = int'(in_dest); end
             end
           end
        1: begin
             mq[mcur].push_back(in_data);
             if (in_eop) mode = 0;
           end
        default: if (in_eop) mode = 0;
      endcase
    end
    for (int d = 0; d < NP; d++) if (popme[d]) mrd[d] = mq[d].pop_front();
    #1;
    for (int d = 0; d < NP; d++) e[d] = (mq[d].size() == 0);
    check("empty_out", empty_out, e);
    for (int d = 0; d < NP; d++) check("rd_data", rd_data[d*32 +: 32], mrd[d]);
    check("drop_cnt", drop_cnt, mdrop[15:0]);
  endtask

  task automatic drive(input bit v, input bit s, input bit e, input logic [1:0] dst,
                       input logic [31:0] dat, input logic [3:0] rd);
    @(negedge clk);
    in_valid = v; in_sop = s; in_eop = e; in_dest = dst; in_data = dat; rd_en = rd;
    step();
  endtask

  task automatic idle(input logic [3:0] rd);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, rd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; rd_en = '0;
    rst_n = 1'b0;
    model_clear();
    #2;
    check("rst_empty", empty_out, 4'hF);
    check("rst_rd_data", rd_data[63:0], 64'd0);
    check("rst_rd_data_hi", rd_data[127:64], 64'd0);
    check("rst_drop", drop_cnt, 16'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int left;
    bit have, first;
    logic [1:0]  gdest;
    logic [31:0] wd;
    logic [3:0]  rd;

    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_dest = '0; in_data = '0; rd_en = '0;
    model_clear();
    do_reset();

    // Pops on all-empty queues change nothing.
    idle(4'hF);
    check("rd_all_empty_e", empty_out, 4'hF);
    check("rd_all_empty_d", rd_data[63:0], 64'd0);

    // 3-word packet to port 2, then drain in order.
    drive(1, 1, 0, 2'd2, 32'hA000_0001, 4'h0);
    drive(1, 0, 0, 2'd1, 32'hA000_0002, 4'h0);
    drive(1, 0, 1, 2'd0, 32'hA000_0003, 4'h0);
    idle(4'h0);
    check("pkt3_empty", empty_out, 4'b1011);
    idle(4'b0100); check("pkt3_w0", rd_data[95:64], 32'hA000_0001);
    idle(4'b0100); check("pkt3_w1", rd_data[95:64], 32'hA000_0002);
    idle(4'b0100); check("pkt3_w2", rd_data[95:64], 32'hA000_0003);
    check("pkt3_drained", empty_out, 4'hF);
    idle(4'b0100); check("pkt3_hold", rd_data[95:64], 32'hA000_0003);

    // Fill VOQ 1, observe backpressure and release after one pop.
    do_reset();
    drive(1, 1, 0, 2'd1, 32'hB000_0000, 4'h0);
    for (int i = 1; i < 16; i++) drive(1, 0, 0, 2'd1, 32'hB000_0000 + i, 4'h0);
    drive(1, 0, 0, 2'd1, 32'hB000_0010, 4'h0);
    check("full_ready", last_rdy, 1'b0);
    drive(1, 0, 0, 2'd1, 32'hB000_0010, 4'b0010);
    check("full_pop_same_cyc", last_rdy, 1'b0);
    drive(1, 0, 0, 2'd1, 32'hB000_0010, 4'h0);
    check("full_release", last_rdy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 2'd1, 32'hB000_0011, 4'b0010);
      if (last_acc) break;
    end
    for (int i = 0; i < 18; i++) idle(4'b0010);

    // Simultaneous write and pop on VOQ 0 holding 5 words.
    do_reset();
    drive(1, 1, 0, 2'd0, 32'hC000_0000, 4'h0);
    for (int i = 1; i < 5; i++) drive(1, 0, 0, 2'd0, 32'hC000_0000 + i, 4'h0);
    for (int i = 5; i < 15; i++) drive(1, 0, i == 14, 2'd0, 32'hC000_0000 + i, 4'b0001);
    for (int i = 0; i < 4; i++) idle(4'b0001);
    check("wr_pop_cnt4", empty_out[0], 1'b0);
    idle(4'b0001);
    check("wr_pop_cnt5", empty_out[0], 1'b1);
    check("wr_pop_last", rd_data[31:0], 32'hC000_000E);

`ifdef VOQ_DROP_EN
    // VOQ 3 above the admission threshold drops the whole next packet.
    do_reset();
    drive(1, 1, 0, 2'd3, 32'hD000_0000, 4'h0);
    for (int i = 1; i < 9; i++) drive(1, 0, i == 8, 2'd3, 32'hD000_0000 + i, 4'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 0, i == 2, 2'd3, 32'hDD00_0000 + i, 4'h0);
      check("drop_ready", last_rdy, 1'b1);
    end
    check("drop_cnt1", drop_cnt, 16'd1);
    for (int i = 0; i < 10; i++) idle(4'b1000);
    check("drop_last_kept", rd_data[127:96], 32'hD000_0008);
`endif

    // Reset in the middle of a packet, then a clean packet afterwards.
    do_reset();
    drive(1, 1, 0, 2'd3, 32'hE000_0000, 4'h0);
    drive(1, 0, 0, 2'd3, 32'hE000_0001, 4'h0);
    @(negedge clk);
    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 32'hE000_0002;
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    check("midrst_empty", empty_out, 4'hF);
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    drive(1, 0, 1, 2'd2, 32'hEEEE_EEEE, 4'h0);
    drive(1, 1, 0, 2'd1, 32'hE100_0000, 4'h0);
    drive(1, 0, 1, 2'd3, 32'hE100_0001, 4'h0);
    idle(4'b0010); check("midrst_w0", rd_data[63:32], 32'hE100_0000);
    idle(4'b0010); check("midrst_w1", rd_data[63:32], 32'hE100_0001);
    check("midrst_drained", empty_out, 4'hF);

    // Randomized traffic: low read rate first to reach full/drop, then high.
    do_reset();
    left = 0; have = 0; first = 0; gdest = '0; wd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!have) begin
        if (left == 0) begin
          left  = (($urandom % 6) == 0) ? int'($urandom_range(9, 20)) : int'($urandom_range(1, MAXW));
          gdest = 2'($urandom);
          first = 1;
        end
        wd   = $urandom;
        have = 1;
      end
      rd = (c < 1500) ? 4'($urandom & $urandom & $urandom) : 4'($urandom);
      if (($urandom % 40) == 0 && first)
        drive(1, 0, $urandom % 2, 2'($urandom), $urandom, rd);
      else begin
        drive(($urandom % 4) != 0, first, left == 1, first ? gdest : 2'($urandom), wd, rd);
        if (last_acc) begin
          have = 0; first = 0; left--;
        end
      end
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(4'hF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
